axi_lite_cmd_master: RTL and testbench

Synthesisable, parametrised AXI4-Lite master fed by a command queue. It replaces the single start_read/start_write/addr/data drive with queued commands, one outstanding transaction, independent AW/W handshakes, in-order responses and a per-phase timeout. It sits between bench/sequencer logic and an axi_lite_if slave port.

---
 rtl/axi_lite_pkg.sv | 17 +
 rtl/axi_lite_cmd_fifo.sv | 43 ++++
 rtl/axi_lite_cmd_master.sv | 185 ++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes and engine state encoding for the AXI4-Lite command master.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_e;

endpackage

// File: rtl/axi_lite_cmd_fifo.sv
// Synchronous command FIFO; dout shows the head entry combinationally while not empty.
module axi_lite_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             push_ok, pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master draining a command FIFO: one outstanding transaction, in-order
// responses, independent AW/W handshakes and a per-phase timeout.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned FW     = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
  logic [ADDR_WIDTH-1:0]  awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]  wdata_q, rsp_data_q;
  logic [STRB_W-1:0]      wstrb_q;
  logic [1:0]             rsp_resp_q;

  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]          fifo_dout;
  logic                   head_write;
  logic [ADDR_WIDTH-1:0]  head_addr;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [STRB_W-1:0]      head_strb;
  logic                   to_hit, aw_ok, w_ok;

  axi_lite_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (areset_n),
    .push  (cmd_valid && !fifo_full),
    .pop   (fifo_pop),
    .din   ({cmd_write, cmd_addr, cmd_data, cmd_strb}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_write, head_addr, head_data, head_strb} = fifo_dout;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  // A channel is finished once its valid has dropped or handshakes this cycle.
  assign aw_ok     = !awvalid_q || awready;
  assign w_ok      = !wvalid_q || wready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      unique case (state_q)
        IDLE: if (!fifo_empty) begin
          cnt_q <= '0;
          if (head_write) begin
            awaddr_q  <= head_addr;
            wdata_q   <= head_data;
            wstrb_q   <= head_strb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR;
          end else begin
            araddr_q  <= head_addr;
            arvalid_q <= 1'b1;
            state_q   <= RD_ADDR;
          end
        end
        WR: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= WR_RESP;
          end else if (to_hit) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rsp_resp_q  <= RESP_TIMEOUT;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        WR_RESP: if (bvalid || to_hit) begin
          bready_q    <= 1'b0;
          rsp_resp_q  <= bvalid ? bresp : RESP_TIMEOUT;
          rsp_data_q  <= '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= RD_DATA;
          end else if (to_hit) begin
            arvalid_q   <= 1'b0;
            rsp_resp_q  <= RESP_TIMEOUT;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RD_DATA: if (rvalid || to_hit) begin
          rready_q    <= 1'b0;
          rsp_resp_q  <= rvalid ? rresp : RESP_TIMEOUT;
          rsp_data_q  <= rvalid ? rdata : '0;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign awaddr    = awaddr_q;
  assign araddr    = araddr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master acting as a hand-driven AXI4-Lite slave.
module tb_axi_lite_cmd_master;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  axi_lite_cmd_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CMD_DEPTH  (4),
    .TIMEOUT    (8)
  ) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_resp  (rsp_resp),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    areset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_strb = '0; rsp_ready = 1'b0;
    clear_slave();
    tick(); tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_valids got %b exp 000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
    end
    checks++; if ({awaddr, araddr, wdata, wstrb, rsp_data, rsp_resp} !== '0) begin
      errors++; $display("FAIL reset_data got awaddr=%h araddr=%h wdata=%h wstrb=%h rsp_data=%h rsp_resp=%b exp all 0",
                         awaddr, araddr, wdata, wstrb, rsp_data, rsp_resp);
    end
    #3 areset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_basic();
    push_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL wr1_awvalid_n1 got %b exp 0", awvalid); end
    tick();
    checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL wr1_valid_n2 got %b exp 11", {awvalid, wvalid}); end
    checks++; if ({awaddr, wdata, wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL wr1_payload got %h/%h/%h exp 00000010/deadbeef/f", awaddr, wdata, wstrb);
    end
    awready = 1'b1; wready = 1'b1;
    tick();
    clear_slave();
    checks++; if ({awvalid, wvalid, bready} !== 3'b001) begin
      errors++; $display("FAIL wr1_after_hs got aw/w/b=%b exp 001", {awvalid, wvalid, bready});
    end
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    clear_slave();
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL wr1_bready_clr got %b exp 0", bready); end
    checks++; if ({rsp_valid, rsp_resp, rsp_data} !== {1'b1, 2'b00, 32'h0}) begin
      errors++; $display("FAIL wr1_rsp got v=%b resp=%b data=%h exp v=1 resp=00 data=0", rsp_valid, rsp_resp, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr1_rsp_drop got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_delayed();
    push_cmd(1'b0, 32'h14, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({arvalid, araddr} !== {1'b1, 32'h14}) begin
        errors++; $display("FAIL rd_ar_stable[%0d] got v=%b addr=%h exp v=1 addr=00000014", i, arvalid, araddr);
      end
      if (i == 3) arready = 1'b1;
      tick();
    end
    clear_slave();
    checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL rd_after_ar got ar/r=%b exp 01", {arvalid, rready}); end
    rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00;
    tick();
    clear_slave();
    checks++; if ({rsp_valid, rsp_resp, rsp_data, rready} !== {1'b1, 2'b00, 32'hCAFEF00D, 1'b0}) begin
      errors++; $display("FAIL rd_rsp got v=%b resp=%b data=%h rready=%b exp v=1 resp=00 data=cafef00d rready=0",
                         rsp_valid, rsp_resp, rsp_data, rready);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_split_handshake();
    int highs = 0;
    int rises = 0;
    logic prev = 1'b0;
    push_cmd(1'b1, 32'h20, 32'h12345678, 4'h3);
    tick();
    for (int c = 1; c <= 9; c++) begin
      clear_slave();
      rsp_ready = 1'b0;
      case (c)
        1: begin
          checks++; if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'h20, 32'h12345678, 4'h3}) begin
            errors++; $display("FAIL wr2_start got v=%b%b %h/%h/%h exp 11 00000020/12345678/3",
                               awvalid, wvalid, awaddr, wdata, wstrb);
          end
          wready = 1'b1;
        end
        2: begin
          checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL wr2_c2 got aw/w=%b exp 10", {awvalid, wvalid}); end
        end
        3: begin
          checks++; if ({awvalid, wvalid, awaddr} !== {2'b10, 32'h20}) begin
            errors++; $display("FAIL wr2_c3 got aw/w=%b%b addr=%h exp 10 00000020", awvalid, wvalid, awaddr);
          end
          awready = 1'b1;
        end
        4: begin
          checks++; if ({awvalid, bready} !== 2'b01) begin errors++; $display("FAIL wr2_c4 got aw/b=%b exp 01", {awvalid, bready}); end
        end
        6: begin bvalid = 1'b1; bresp = 2'b10; end
        7: begin
          checks++; if ({rsp_valid, rsp_resp, rsp_data} !== {1'b1, 2'b10, 32'h0}) begin
            errors++; $display("FAIL wr2_rsp got v=%b resp=%b data=%h exp v=1 resp=10 data=0", rsp_valid, rsp_resp, rsp_data);
          end
          rsp_ready = 1'b1;
        end
        8: begin
          checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr2_rsp_drop got %b exp 0", rsp_valid); end
        end
        default: ;
      endcase
      if (bready && !prev) rises++;
      if (bready) highs++;
      prev = bready;
      tick();
    end
    clear_slave();
    rsp_ready = 1'b0;
    checks++; if (rises !== 1 || highs !== 3) begin
      errors++; $display("FAIL wr2_bready_phase got rises=%0d cycles=%0d exp rises=1 cycles=3", rises, highs);
    end
  endtask

  task automatic test_fifo_full();
    int accepted = 0;
    int k;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100 + 32'(4 * i); cmd_data = '0; cmd_strb = '0;
      if (cmd_ready) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (accepted !== 5) begin errors++; $display("FAIL ff_accepted got %0d exp 5", accepted); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ff_full_ready got %b exp 0", cmd_ready); end
    for (k = 0; k < 5; k++) begin
      for (int w = 0; w < 20 && !arvalid; w++) tick();
      checks++; if ({arvalid, araddr} !== {1'b1, 32'h100 + 32'(4 * k)}) begin
        errors++; $display("FAIL ff_araddr[%0d] got v=%b addr=%h exp v=1 addr=%h", k, arvalid, araddr, 32'h100 + 32'(4 * k));
      end
      arready = 1'b1;
      tick();
      clear_slave();
      rvalid = 1'b1; rdata = 32'hA0 + 32'(k); rresp = 2'b00;
      tick();
      clear_slave();
      checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hA0 + 32'(k)}) begin
        errors++; $display("FAIL ff_rsp[%0d] got v=%b data=%h exp v=1 data=%h", k, rsp_valid, rsp_data, 32'hA0 + 32'(k));
      end
      if (k == 0) begin
        for (int h = 0; h < 3; h++) begin
          checks++; if ({cmd_ready, rsp_valid} !== 2'b01) begin
            errors++; $display("FAIL ff_hold[%0d] got ready/rsp_valid=%b exp 01", h, {cmd_ready, rsp_valid});
          end
          tick();
        end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if (k == 0) begin
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ff_ready_back got %b exp 1", cmd_ready); end
      end
    end
    tick(); tick(); tick();
    checks++; if ({arvalid, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL ff_no_sixth got ar/rsp=%b exp 00", {arvalid, rsp_valid});
    end
  endtask

  task automatic test_timeout();
    push_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL to_arvalid[%0d] got %b exp 1", i, arvalid); end
      if (i == 0) begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_data = 32'h55AA55AA; cmd_strb = 4'hC; end
      else cmd_valid = 1'b0;
      tick();
    end
    checks++; if ({arvalid, rready, rsp_valid, rsp_resp, rsp_data} !== {3'b001, 2'b11, 32'h0}) begin
      errors++; $display("FAIL to_rsp got ar=%b r=%b v=%b resp=%b data=%h exp ar=0 r=0 v=1 resp=11 data=0",
                         arvalid, rready, rsp_valid, rsp_resp, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL to_idle_aw got %b exp 0", awvalid); end
    tick();
    checks++; if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'h44, 32'h55AA55AA, 4'hC}) begin
      errors++; $display("FAIL to_next_cmd got v=%b%b %h/%h/%h exp 11 00000044/55aa55aa/c", awvalid, wvalid, awaddr, wdata, wstrb);
    end
    awready = 1'b1; wready = 1'b1;
    tick();
    clear_slave();
    bvalid = 1'b1;
    tick();
    clear_slave();
    checks++; if ({rsp_valid, rsp_resp} !== 3'b100) begin
      errors++; $display("FAIL to_next_rsp got v=%b resp=%b exp v=1 resp=00", rsp_valid, rsp_resp);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_data = 32'h1; cmd_strb = 4'hF;
    tick();
    cmd_addr = 32'h84;
    tick();
    cmd_addr = 32'h88;
    awready = 1'b1; wready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    clear_slave();
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL rst_in_wr_resp got bready=%b exp 1", bready); end
    areset_n = 1'b0;
    #1;
    checks++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, awaddr, wdata, wstrb} !== '0) begin
      errors++; $display("FAIL rst_async got v=%b awaddr=%h wdata=%h wstrb=%h exp all 0",
                         {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, awaddr, wdata, wstrb);
    end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    tick();
    #2 areset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b1000000) begin
        errors++; $display("FAIL rst_quiet[%0d] got %b exp 1000000", i, {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_delayed();
    test_split_handshake();
    test_fifo_full();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
